// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flow controller for a 5-stage in-order core.
// Decodes memory freezes, branch mispredict recovery and load-use stalls
// into per-stage write enables and flushes, and keeps stall/flush
// statistics plus a sticky memory-timeout flag.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_useRs,
    input  logic        ID_useRt,
    input  logic        EX_memRead,
    input  logic [4:0]  EX_wreg,
    input  logic        EX_mispredict,
    input  logic        mem_ready,
    input  logic        clr_cnt,
    output logic        PC_wEn,
    output logic        IFID_wEn,
    output logic        IDEX_wEn,
    output logic        EXMEM_wEn,
    output logic        MEMWB_wEn,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        pc_redirect,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        mem_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FREEZE = 2'b01,
        FLUSH  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic lu;
    logic in_flush;
    logic stall_inc;
    logic flush_inc;

    // Saturating +1 for the 16-bit statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating +1 for the memory wait counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Hazard decode: freeze beats mispredict beats load-use; while reset is
    // held the FLUSH squash is suppressed so decoding looks like RUN.
    always_comb begin
        lu = EX_memRead && (EX_wreg != 5'd0) &&
             ((ID_useRs && (EX_wreg == ID_Rs)) || (ID_useRt && (EX_wreg == ID_Rt)));
        in_flush    = rst && (state_q == FLUSH);
        PC_wEn      = 1'b1;
        IFID_wEn    = 1'b1;
        IDEX_wEn    = 1'b1;
        EXMEM_wEn   = 1'b1;
        MEMWB_wEn   = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        pc_redirect = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = RUN;
        if (!mem_ready) begin
            PC_wEn    = 1'b0;
            IFID_wEn  = 1'b0;
            IDEX_wEn  = 1'b0;
            EXMEM_wEn = 1'b0;
            MEMWB_wEn = 1'b0;
            state_d   = FREEZE;
        end else if (EX_mispredict) begin
            pc_redirect = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            flush_inc   = 1'b1;
            state_d     = FLUSH;
        end else if (in_flush) begin
            // The wrong-path fetch latched on the redirect edge is squashed.
            IFID_Flush = 1'b1;
        end else if (lu) begin
            // One bubble suffices: the load moves on to MEM next edge.
            PC_wEn     = 1'b0;
            IFID_wEn   = 1'b0;
            IDEX_Flush = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    // Statistics and memory-wait bookkeeping; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (stall_inc) stall_cnt_d = sat_inc16(stall_cnt_q);
            if (flush_inc) flush_cnt_d = sat_inc16(flush_cnt_q);
        end
        wait_cnt_d    = mem_ready ? 8'd0 : sat_inc8(wait_cnt_q);
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == 8'hFF);
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            stall_cnt_q   <= 16'd0;
            flush_cnt_q   <= 16'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign state       = state_q;

endmodule
